// File: rtl/dp_ram_be_init_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package dp_ram_pkg;

    // Init sequencer states: clearing the array, then normal service.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest word byte_merge handles; narrower words are zero-extended in and truncated out.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    function automatic int num_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // Byte i of the result comes from new_w when be[i] is set, otherwise from old_w.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_be_init_if.sv
// Port A write / port B read bus of the dual-port RAM.
interface dp_ram_be_init_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                    init_busy;
    logic                    we_a;
    logic [DATA_WIDTH/8-1:0] be_a;
    logic [ADDR_WIDTH-1:0]   addr_a;
    logic [DATA_WIDTH-1:0]   data_a;
    logic                    re_b;
    logic [ADDR_WIDTH-1:0]   addr_b;
    logic [DATA_WIDTH-1:0]   data_b;
    logic                    valid_b;

    modport master (
        input  init_busy, data_b, valid_b,
        output we_a, be_a, addr_a, data_a, re_b, addr_b
    );

    modport slave (
        output init_busy, data_b, valid_b,
        input  we_a, be_a, addr_a, data_a, re_b, addr_b
    );
endinterface

// File: rtl/dp_ram_be_init_init_seq.sv
// Post-reset clear sequencer: walks every address once, then hands the array to port A.
module dp_ram_init_seq
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  init_busy,
    output logic                  run
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Next state: one location cleared per cycle, RUN after the last address.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we   = 1'b0;
        init_busy = 1'b0;
        case (state_q)
            INIT: begin
                init_busy = 1'b1;
                init_we   = !rst;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    // State and address counter; reset always restarts the clear from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_addr = cnt_q;
    assign run       = (state_q == RUN);
endmodule

// File: rtl/dp_ram_be_init.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, collision modes and init clear.
module dp_ram_be_init
    import dp_ram_pkg::*;
#(
    parameter int                        ADDR_WIDTH = 4,
    parameter int                        DATA_WIDTH = 32,
    parameter int                        RD_LATENCY = 1,
    parameter int                        BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst,
    dp_ram_be_init_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = num_bytes(DATA_WIDTH);

    if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_latency
        $fatal(1, "dp_ram_be_init: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH >= MAX_DATA_W) begin : g_bad_width
        $fatal(1, "dp_ram_be_init: DATA_WIDTH must be a multiple of 8 below MAX_DATA_W");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_we, init_busy, run;
    logic [ADDR_WIDTH-1:0] init_addr;

    dp_ram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_busy (init_busy),
        .run       (run)
    );

    assign bus.init_busy = init_busy;

    // Port A word after applying byte enables to the current contents.
    logic [DATA_WIDTH-1:0] merged;
    assign merged = DATA_WIDTH'(byte_merge(MAX_DATA_W'(mem[bus.addr_a]),
                                           MAX_DATA_W'(bus.data_a),
                                           MAX_BYTES'(bus.be_a)));

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Write port mux: the sequencer owns the array during INIT, port A afterwards.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addr_a;
        wr_data = merged;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_addr;
            wr_data = INIT_VALUE;
        end else if (run && !rst && bus.we_a && (bus.be_a != '0)) begin
            wr_en = 1'b1;
        end
    end

    // Array storage; never reset, the sequencer clears it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A colliding read sees either the merged word (forwarding) or the old word.
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;
    assign rd_fire = run && bus.re_b;
    assign rd_word = (BYPASS != 0 && bus.we_a && (bus.addr_a == bus.addr_b))
                   ? merged : mem[bus.addr_b];

    // ---- stage p1: array read register ----
    logic                  vld_p1_q, vld_p1_d;
    logic [DATA_WIDTH-1:0] data_p1_q, data_p1_d;

    // Capture a read result; data holds when no read is issued.
    always_comb begin
        vld_p1_d  = rd_fire;
        data_p1_d = rd_fire ? rd_word : data_p1_q;
    end

    // Stage p1 register; reset cancels anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        // ---- stage p2: extra output register ----
        logic                  vld_p2_q, vld_p2_d;
        logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;

        // Advance only valid results so data_b holds between reads.
        always_comb begin
            vld_p2_d  = vld_p1_q;
            data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
        end

        // Stage p2 register; reset cancels anything in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p2_q  <= 1'b0;
                data_p2_q <= '0;
            end else begin
                vld_p2_q  <= vld_p2_d;
                data_p2_q <= data_p2_d;
            end
        end

        assign bus.valid_b = vld_p2_q;
        assign bus.data_b  = data_p2_q;
    end else begin : g_lat1
        assign bus.valid_b = vld_p1_q;
        assign bus.data_b  = data_p1_q;
    end

    logic unused_nb;
    assign unused_nb = (NB == 0);
endmodule

// File: tb/tb_dp_ram_be_init.sv
// Bench for dp_ram_be_init: two instances (latency 1 / forwarding, latency 2 / read-first).
module tb_dp_ram_be_init;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_a = 1'b0;
    logic [3:0]  be_a = 4'h0;
    logic [3:0]  addr_a = 4'h0;
    logic [31:0] data_a = 32'h0;
    logic        re_b = 1'b0;
    logic [3:0]  addr_b = 4'h0;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    dp_ram_be_init_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifa ();
    dp_ram_be_init_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifb ();

    assign ifa.we_a = we_a;   assign ifb.we_a = we_a;
    assign ifa.be_a = be_a;   assign ifb.be_a = be_a;
    assign ifa.addr_a = addr_a; assign ifb.addr_a = addr_a;
    assign ifa.data_a = data_a; assign ifb.data_a = data_a;
    assign ifa.re_b = re_b;   assign ifb.re_b = re_b;
    assign ifa.addr_b = addr_b; assign ifb.addr_b = addr_b;

    dp_ram_be_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1), .BYPASS(1),
                     .INIT_VALUE(32'h0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dp_ram_be_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .BYPASS(0),
                     .INIT_VALUE(32'h0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Behavioural model: memory image plus a list of pending results with due cycles.
    typedef struct { int due; logic [31:0] d; } rd_t;
    localparam int LAT [2] = '{1, 2};
    localparam int BYP [2] = '{1, 0};
    logic [31:0] mmem [2][16];
    rd_t         pq [2][$];
    logic [31:0] exp_data [2];
    logic        exp_vld [2];
    logic        m_busy = 1'b1;
    int          m_cnt = 0;
    int          cyc = 0;
    bit          seen_rst = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            seen_rst = 1'b1;
            m_busy = 1'b1;
            m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                pq[k].delete();
                exp_vld[k] = 1'b0;
                exp_data[k] = 32'h0;
            end
        end else begin
            if (m_busy) begin
                for (int k = 0; k < 2; k++) mmem[k][m_cnt] = 32'h0;
                m_cnt++;
                if (m_cnt == 16) m_busy = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (re_b) begin
                        rd_t r;
                        r.d = mmem[k][addr_b];
                        if (BYP[k] != 0 && we_a && addr_a == addr_b) r.d = mrg(r.d, data_a, be_a);
                        r.due = cyc + LAT[k] - 1;
                        pq[k].push_back(r);
                    end
                    if (we_a) mmem[k][addr_a] = mrg(mmem[k][addr_a], data_a, be_a);
                end
            end
            for (int k = 0; k < 2; k++) begin
                exp_vld[k] = 1'b0;
                if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
                    exp_vld[k] = 1'b1;
                    exp_data[k] = pq[k][0].d;
                    void'(pq[k].pop_front());
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (seen_rst) begin
            chk("busy_a", 32'(ifa.init_busy), 32'(m_busy));
            chk("busy_b", 32'(ifb.init_busy), 32'(m_busy));
            chk("valid_a", 32'(ifa.valid_b), 32'(exp_vld[0]));
            chk("valid_b", 32'(ifb.valid_b), 32'(exp_vld[1]));
            chk("data_a", ifa.data_b, exp_data[0]);
            chk("data_b", ifb.data_b, exp_data[1]);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we_a = 1'b1; addr_a = a; data_a = d; be_a = be;
        @(negedge clk);
        we_a = 1'b0; be_a = 4'h0;
    endtask

    task automatic rd(input string name, input logic [3:0] a,
                      input logic [31:0] exp_a, input logic [31:0] exp_b);
        re_b = 1'b1; addr_b = a;
        @(negedge clk);
        re_b = 1'b0;
        chk({name, "_va"}, 32'(ifa.valid_b), 32'd1);
        chk({name, "_da"}, ifa.data_b, exp_a);
        chk({name, "_vb_early"}, 32'(ifb.valid_b), 32'd0);
        @(negedge clk);
        chk({name, "_vb"}, 32'(ifb.valid_b), 32'd1);
        chk({name, "_db"}, ifb.data_b, exp_b);
        chk({name, "_va_once"}, 32'(ifa.valid_b), 32'd0);
    endtask

    // Count cycles from rst release until init_busy falls; bounded.
    task automatic wait_init(input string name, output bit saw_valid);
        int n;
        n = 0;
        saw_valid = 1'b0;
        while (ifa.init_busy && n < 40) begin
            @(negedge clk);
            n++;
            if (ifa.valid_b || ifb.valid_b) saw_valid = 1'b1;
        end
        chk(name, n, 16);
    endtask

    initial begin
        bit sv;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(ifa.init_busy), 32'd1);
        chk("rst_valid", 32'(ifb.valid_b), 32'd0);
        chk("rst_data", ifb.data_b, 32'h0);
        rst = 1'b0;
        wait_init("init_len", sv);

        // Sweep all addresses back to back; every read returns the init value.
        for (int i = 0; i < 16; i++) begin
            re_b = 1'b1; addr_b = 4'(i);
            @(negedge clk);
            chk("sweep_va", 32'(ifa.valid_b), 32'd1);
            chk("sweep_da", ifa.data_b, 32'h0);
            if (i > 0) chk("sweep_vb", 32'(ifb.valid_b), 32'd1);
        end
        re_b = 1'b0;
        @(negedge clk);
        chk("sweep_vb_last", 32'(ifb.valid_b), 32'd1);
        @(negedge clk);
        chk("sweep_idle", 32'(ifb.valid_b), 32'd0);

        // Byte-enable merge.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd("be_merge", 4'd3, 32'hAA22CC44, 32'hAA22CC44);
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        rd("be_none", 4'd3, 32'hAA22CC44, 32'hAA22CC44);
        wr(4'd15, 32'h5A5A0F0F, 4'b1000);
        rd("be_top", 4'd15, 32'h5A000000, 32'h5A000000);

        // Collision, then read-after-write.
        wr(4'd5, 32'h0, 4'b1111);
        we_a = 1'b1; addr_a = 4'd5; data_a = 32'hDEADBEEF; be_a = 4'hF;
        re_b = 1'b1; addr_b = 4'd5;
        @(negedge clk);
        we_a = 1'b0; be_a = 4'h0;
        chk("coll_a", ifa.data_b, 32'hDEADBEEF);
        @(negedge clk);
        re_b = 1'b0;
        chk("raw_a", ifa.data_b, 32'hDEADBEEF);
        chk("coll_b", ifb.data_b, 32'h0);
        @(negedge clk);
        chk("raw_b", ifb.data_b, 32'hDEADBEEF);

        // Pipelined reads through the latency-2 instance.
        wr(4'd0, 32'h10000000, 4'hF);
        wr(4'd1, 32'h20000001, 4'hF);
        wr(4'd2, 32'h30000002, 4'hF);
        for (int i = 0; i < 3; i++) begin
            re_b = 1'b1; addr_b = 4'(i);
            @(negedge clk);
            if (i == 0) chk("pipe_first_b", 32'(ifb.valid_b), 32'd0);
            else chk("pipe_b", ifb.data_b, 32'h10000000 + 32'h10000001 * 32'(i - 1));
        end
        re_b = 1'b0;
        @(negedge clk);
        chk("pipe_b_last", ifb.data_b, 32'h30000002);
        chk("pipe_b_lastv", 32'(ifb.valid_b), 32'd1);
        @(negedge clk);
        chk("pipe_b_end", 32'(ifb.valid_b), 32'd0);
        chk("pipe_b_hold", ifb.data_b, 32'h30000002);

        // Reset with a latency-2 read in flight.
        re_b = 1'b1; addr_b = 4'd3;
        @(negedge clk);
        re_b = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("flush_vb", 32'(ifb.valid_b), 32'd0);
        chk("flush_db", ifb.data_b, 32'h0);
        chk("flush_da", ifa.data_b, 32'h0);
        rst = 1'b0;
        re_b = 1'b1; addr_b = 4'd3;

        // Reset pulse in the middle of init; reads during init are ignored.
        repeat (7) @(negedge clk);
        chk("mid_busy", 32'(ifa.init_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(ifb.init_busy), 32'd1);
        rst = 1'b0;
        wait_init("reinit_len", sv);
        re_b = 1'b0;
        chk("init_no_valid", 32'(sv), 32'd0);
        @(negedge clk);
        rd("cleared", 4'd3, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
